bf16_sub: RTL
=============

# bf16_sub

Pipelined BFloat16 subtractor computing z = a - b. It is the inverse-operation companion of the combinational bf16 adder. It accepts one operand pair per cycle over a valid/ready handshake and returns a packed, normalised bf16 result three cycles later. It sits in the datapath next to the adder and is used where a registered, back-pressurable subtract with correct result sign and special-value handling is required.

## Interface
- E, 8, exponent width
- M, 7, stored mantissa width (hidden 1 not included)
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- valid_i  in  1  operand pair valid
- ready_o  out  1  block can accept operands this cycle
- sa_i / ea_i / ma_i  in  1 / E / M  operand a: sign, exponent, mantissa
- sb_i / eb_i / mb_i  in  1 / E / M  operand b: sign, exponent, mantissa
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result
- s_o / e_o / m_o  out  1 / E / M  result z: sign, exponent, mantissa
- nan_o  out  1  result is NaN; qualified by valid_o
- ovf_o  out  1  finite inputs overflowed; qualified by valid_o

## Operation
- Effective operation: b' = {~sb_i, eb_i, mb_i}; the block computes a + b'. The effective op is a subtract when sa_i == ~sb_i is false, i.e. when sa_i ^ ~sb_i = 1.
- Subnormal inputs (exp == 0) are flushed to signed zero before use.
- Stage 1, align:
  - Order operands by magnitude {e,m}: x is the larger, y the smaller.
  - d = ex - ey.
  - Right-shift {1, my} by d into an M+4 bit field holding guard, round and sticky bits; d >= M+3 leaves only sticky.
  - Classify special values.
- Stage 2, add/sub: compute {1,mx,000} ± aligned y on M+5 bits, then run a leading-zero count on the result.
- Stage 3, normalise, round and pack:
  - Carry out: shift right 1, exponent + 1.
  - Leading zeros k: shift left k, exponent - k.
  - Round the result, then renormalise if rounding carries out.
- Result sign:
  - Normal case: the sign of x (sa_i if x = a, otherwise ~sb_i).
  - Exact zero from cancellation: +0.
  - (-0) - (+0) = -0.
- Special values:
  - Any NaN input, or inf - inf with like signs: z = 0x7FC0 and nan_o = 1.
  - Otherwise, one inf input: z is that inf (after the b negation).
- Underflow (normalised exponent <= 0): signed zero.
- Overflow (exponent >= 255 after rounding): ovf_o = 1; the result depends on the rounding mode (see Configuration).

## Timing
- Latency: exactly 3 accepted cycles from a valid_i && ready_o transfer to valid_o. Throughput is 1 per cycle.
- Global stall:
  - advance = ~valid_o | ready_i.
  - ready_o = advance, a combinational function of the output-stage valid and ready_i.
  - All stage registers, data and per-stage valid bits, load only on advance.
- Bubbles propagate as stage valid = 0; they are not collapsed.
- Output stability: while valid_o && !ready_i, all outputs hold stable.
- Output transfer: occurs on valid_o && ready_i. Back-to-back transfers are allowed.
- Reset:
  - All stage valids = 0; valid_o = 0; s_o, e_o, m_o, nan_o, ovf_o = 0.
  - ready_o = 1 out of reset.
- Reset asserted mid-operation discards all in-flight results. No partial output appears after release.
- valid_i while ready_o = 0 has no effect. The upstream must hold its data.

## Configuration
- BF16_SUB_RNE_EN defined:
  - Round to nearest, ties to even, using guard/round/sticky.
  - Overflow yields signed infinity (exp 0xFF, m 0).
- BF16_SUB_RNE_EN undefined:
  - Round toward zero, with guard/round/sticky discarded after normalisation.
  - Overflow yields signed max finite (0x7F7F / 0xFF7F).
- Latency and handshake are identical in both builds.

## Structure
- Shared package bf16_pkg holds:
  - E, M, BIAS = 127, EXP_MAX = 8'hFF.
  - QNAN = 16'h7FC0.
  - A special-class enum {ZERO, NORM, INF, NAN}.
- Reuse the existing lzc module as the single sub-module for the stage 2 count. Pad its input to a power of two with trailing ones.
- Everything else stays inline: three register stages plus combinational logic per stage.

## Test plan
- Cancellation: 0x3F80 - 0x3F80 -> 0x0000 on the 3rd cycle after accept; 0x8000 - 0x0000 -> 0x8000.
- Basic sub/add:
  - 0x4040 - 0x3F80 -> 0x4000.
  - 0x3F80 - 0xBF80 -> 0x4000.
  - 0x3F80 - 0x3B80 -> 0x3F7F (exact, exponent decrement).
- Rounding tie: 0x3F80 - 0x3B00 -> 0x3F80 with BF16_SUB_RNE_EN, 0x3F7F without.
- Specials:
  - 0x7F80 - 0x7F80 -> 0x7FC0 with nan_o = 1.
  - 0x7F7F - 0xFF7F -> ovf_o = 1; 0x7F80 with RNE, 0x7F7F without.
- Back-pressure: stream 6 pairs with ready_i = 0 for cycles 4-8.
  - ready_o = 0 during the stall.
  - All 6 results emerge in order, unchanged.
  - No duplicates or losses.
- Reset mid-stream: assert rst with 3 results in flight.
  - valid_o = 0 immediately and all outputs 0.
  - After release, the first output is the first pair accepted post-reset.

Source files
------------

// File: rtl/bf16_pkg.sv
// Shared bf16 field widths, constants and special-value classification.
// Combinational helpers only; no latency or back-pressure of its own.
package bf16_pkg;

  localparam int E = 8;
  localparam int M = 7;
  localparam int BIAS = 127;
  localparam logic [E-1:0] EXP_MAX = 8'hFF;
  localparam logic [15:0] QNAN = 16'h7FC0;

  // Aligned significand: hidden 1, M bits, guard, round, sticky; plus one carry bit.
  localparam int AW = M + 4;
  localparam int SW = M + 5;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} cls_e;

  // Subnormals classify as ZERO so callers flush them.
  function automatic cls_e classify(input logic [E-1:0] e, input logic [M-1:0] m);
    if (e == '0) return ZERO;
    else if (e == EXP_MAX) return (m == '0) ? INF : NAN;
    else return NORM;
  endfunction

endpackage

// File: rtl/lzc.sv
// Leading-zero counter; cnt = W when din is all zeros.
// Purely combinational, no handshake.
module lzc #(
  parameter int W  = 16,
  parameter int CW = $clog2(W) + 1
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] cnt
);

  // Scanning upward, the last set bit seen is the most significant one.
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (din[i]) cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/bf16_sub.sv
// Pipelined bf16 z = a - b: 3-cycle latency, 1/cycle; one global stall (ready_o = ~valid_o | ready_i)
// freezes every stage. BF16_SUB_RNE_EN selects round-nearest-even and inf on overflow; default truncates.
module bf16_sub
  import bf16_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         sa_i,
  input  logic [E-1:0] ea_i,
  input  logic [M-1:0] ma_i,
  input  logic         sb_i,
  input  logic [E-1:0] eb_i,
  input  logic [M-1:0] mb_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         s_o,
  output logic [E-1:0] e_o,
  output logic [M-1:0] m_o,
  output logic         nan_o,
  output logic         ovf_o
);

`ifdef BF16_SUB_RNE_EN
  localparam bit RNE_EN = 1'b1;
`else
  localparam bit RNE_EN = 1'b0;
`endif

  logic advance;
  assign advance = ~valid_o | ready_i;
  assign ready_o = advance;

  // ---------------- stage 1: classify, order, align ----------------
  cls_e ca, cb, cx, cy;
  logic sb_n, swap, sx1, nan1, inf1, inf_s1;
  logic [E-1:0] ex, ey, d;
  logic [M-1:0] ma_f, mb_f, mx, my;
  logic [AW-1:0] x_al, y_full, y_al;
  logic [2*AW-1:0] y_sh;

  always_comb begin
    sb_n = ~sb_i;
    ca = classify(ea_i, ma_i);
    cb = classify(eb_i, mb_i);
    ma_f = (ca == ZERO) ? '0 : ma_i;
    mb_f = (cb == ZERO) ? '0 : mb_i;
    swap = {eb_i, mb_f} > {ea_i, ma_f};
    ex  = swap ? eb_i : ea_i;
    ey  = swap ? ea_i : eb_i;
    mx  = swap ? mb_f : ma_f;
    my  = swap ? ma_f : mb_f;
    cx  = swap ? cb : ca;
    cy  = swap ? ca : cb;
    sx1 = swap ? sb_n : sa_i;
    d   = ex - ey;
    x_al   = {(cx != ZERO), mx, 3'b000};
    y_full = {(cy != ZERO), my, 3'b000};
    y_sh   = {y_full, {AW{1'b0}}} >> d;
    if (d >= E'(AW)) y_al = {{(AW-1){1'b0}}, (cy != ZERO)};
    else             y_al = y_sh[2*AW-1:AW] | {{(AW-1){1'b0}}, |y_sh[AW-1:0]};
    nan1   = (ca == NAN) || (cb == NAN) || ((ca == INF) && (cb == INF) && (sa_i != sb_n));
    inf1   = (ca == INF) || (cb == INF);
    inf_s1 = (ca == INF) ? sa_i : sb_n;
  end

  logic s1_vld, s1_nan, s1_inf, s1_inf_s, s1_sx, s1_sub;
  logic [E-1:0] s1_ex;
  logic [AW-1:0] s1_xal, s1_yal;

  // ---------------- stage 2: add/sub and leading-zero count ----------------
  logic [SW-1:0] sum;
  logic [4:0] lz;

  assign sum = s1_sub ? ({1'b0, s1_xal} - {1'b0, s1_yal})
                      : ({1'b0, s1_xal} + {1'b0, s1_yal});

  lzc #(.W(SW + 4), .CW(5)) u_lzc (
    .din ({sum, 4'hF}),
    .cnt (lz)
  );

  logic s2_vld, s2_nan, s2_inf, s2_inf_s, s2_sx, s2_sub;
  logic [E-1:0] s2_ex;
  logic [SW-1:0] s2_sum;
  logic [4:0] s2_lz;

  // ---------------- stage 3: normalise, round, pack ----------------
  logic [3:0] k;
  logic [AW-1:0] nrm;
  logic [9:0] exp_n, exp_r;
  logic inc, uf, of;
  logic [M+1:0] mant9;
  logic [M-1:0] mant_r;
  logic z_s, z_nan, z_ovf;
  logic [E-1:0] z_e;
  logic [M-1:0] z_m;

  always_comb begin
    k = 4'(s2_lz - 5'd1);
    if (s2_sum[SW-1]) begin
      nrm   = {s2_sum[SW-1:2], s2_sum[1] | s2_sum[0]};
      exp_n = {2'b00, s2_ex} + 10'd1;
    end else begin
      nrm   = s2_sum[AW-1:0] << k;
      exp_n = {2'b00, s2_ex} - {6'd0, k};
    end
    inc    = RNE_EN & nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
    mant9  = {1'b0, nrm[AW-1:3]} + {{(M+1){1'b0}}, inc};
    mant_r = mant9[M+1] ? mant9[M:1] : mant9[M-1:0];
    exp_r  = exp_n + {9'd0, mant9[M+1]};
    uf     = exp_n[9] | (exp_n == 10'd0);
    of     = ~exp_r[9] & (exp_r >= 10'd255);

    z_s = s2_sx; z_e = exp_r[E-1:0]; z_m = mant_r; z_nan = 1'b0; z_ovf = 1'b0;
    if (s2_nan) begin
      {z_s, z_e, z_m} = QNAN;
      z_nan = 1'b1;
    end else if (s2_inf) begin
      z_s = s2_inf_s; z_e = EXP_MAX; z_m = '0;
    end else if (s2_sum == '0) begin
      // Cancellation gives +0; only like-signed zeros keep their sign.
      z_s = ~s2_sub & s2_sx; z_e = '0; z_m = '0;
    end else if (uf) begin
      z_e = '0; z_m = '0;
    end else if (of) begin
      z_ovf = 1'b1;
      z_e   = RNE_EN ? EXP_MAX : EXP_MAX - 8'd1;
      z_m   = RNE_EN ? '0 : '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0; s1_nan <= 1'b0; s1_inf <= 1'b0; s1_inf_s <= 1'b0;
      s1_sx <= 1'b0; s1_sub <= 1'b0; s1_ex <= '0; s1_xal <= '0; s1_yal <= '0;
      s2_vld <= 1'b0; s2_nan <= 1'b0; s2_inf <= 1'b0; s2_inf_s <= 1'b0;
      s2_sx <= 1'b0; s2_sub <= 1'b0; s2_ex <= '0; s2_sum <= '0; s2_lz <= '0;
      valid_o <= 1'b0; s_o <= 1'b0; e_o <= '0; m_o <= '0; nan_o <= 1'b0; ovf_o <= 1'b0;
    end else if (advance) begin
      s1_vld <= valid_i; s1_nan <= nan1; s1_inf <= inf1; s1_inf_s <= inf_s1;
      s1_sx <= sx1; s1_sub <= sa_i ^ sb_n; s1_ex <= ex; s1_xal <= x_al; s1_yal <= y_al;
      s2_vld <= s1_vld; s2_nan <= s1_nan; s2_inf <= s1_inf; s2_inf_s <= s1_inf_s;
      s2_sx <= s1_sx; s2_sub <= s1_sub; s2_ex <= s1_ex; s2_sum <= sum; s2_lz <= lz;
      valid_o <= s2_vld; s_o <= z_s; e_o <= z_e; m_o <= z_m; nan_o <= z_nan; ovf_o <= z_ovf;
    end
  end

endmodule
